// File: rtl/l2_mem_axi_bridge.sv
// L2 cache memory-port responder: turns line refills, write-backs and single uncached
// accesses into AXI4 INCR bursts (or single beats) on a 32-bit master, one at a time.
module l2_mem_axi_bridge #(
    parameter int         offset_width = 3,
    parameter logic [3:0] ID_VAL       = 4'd0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [31:0]                   addr_l2cache_mem_r,
    input  logic [31:0]                   addr_l2cache_mem_w,
    input  logic [(32<<offset_width)-1:0] dout_l2cache_mem,
    output logic [(32<<offset_width)-1:0] din_mem_l2cache,
    input  logic                          l2cache_mem_req_r,
    input  logic                          l2cache_mem_req_w,
    input  logic                          l2cache_mem_rdy,
    input  logic                          l2cache_mem_SUC,
    input  logic [3:0]                    l2cache_mem_wstrb,
    input  logic [1:0]                    l2cache_mem_size,
    output logic                          mem_l2cache_addrOK_r,
    output logic                          mem_l2cache_addrOK_w,
    output logic                          mem_l2cache_dataOK,
    output logic [31:0]                   araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic [3:0]                    arid,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [31:0]                   rdata,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    output logic [31:0]                   awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic [3:0]                    awid,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [31:0]                   wdata,
    output logic [3:0]                    wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic                          bvalid,
    output logic                          bready
);

    localparam int         BEATS    = 1 << offset_width;
    localparam int         LW       = 32 * BEATS;
    localparam int         CW       = (offset_width > 0) ? offset_width : 1;
    localparam logic [7:0] LINE_LEN = 8'(BEATS - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_RDONE, S_AW, S_W, S_B} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [LW-1:0]   line_q, line_d;
    logic [LW-1:0]   rbuf_q, rbuf_d;
    logic            suc_q, suc_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [1:0]      size_q, size_d;

    logic [7:0]      burstLen;
    logic [2:0]      burstSize;
    logic [CW+4:0]   wordBase;
    logic            lastBeat;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rbuf_q  <= '0;
            suc_q   <= 1'b0;
            wstrb_q <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rbuf_q  <= rbuf_d;
            suc_q   <= suc_d;
            wstrb_q <= wstrb_d;
            size_q  <= size_d;
        end
    end

    // Outputs are forced low while reset is held, so a mid-burst reset drops every valid at once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        rbuf_d  = rbuf_q;
        suc_d   = suc_q;
        wstrb_d = wstrb_q;
        size_d  = size_q;

        mem_l2cache_addrOK_r = 1'b0;
        mem_l2cache_addrOK_w = 1'b0;
        mem_l2cache_dataOK   = 1'b0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        arid    = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = '0;
        awlen   = '0;
        awsize  = '0;
        awburst = '0;
        awid    = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;

        burstLen  = suc_q ? 8'd0 : LINE_LEN;
        burstSize = suc_q ? {1'b0, ((size_q == 2'd3) ? 2'd2 : size_q)} : 3'd2;
        wordBase  = {cnt_q, 5'd0};
        lastBeat  = (8'(cnt_q) == burstLen);
        din_mem_l2cache = rstn ? '0 : rbuf_q;

        if (!rstn) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    // Write first: a dirty eviction must reach memory before the refill of that line
                    if (l2cache_mem_req_w) begin
                        mem_l2cache_addrOK_w = 1'b1;
                        addr_d  = addr_l2cache_mem_w;
                        line_d  = dout_l2cache_mem;
                        suc_d   = l2cache_mem_SUC;
                        wstrb_d = l2cache_mem_wstrb;
                        size_d  = l2cache_mem_size;
                        state_d = S_AW;
                    end else if (l2cache_mem_req_r) begin
                        mem_l2cache_addrOK_r = 1'b1;
                        addr_d  = addr_l2cache_mem_r;
                        suc_d   = l2cache_mem_SUC;
                        size_d  = l2cache_mem_size;
                        rbuf_d  = '0;
                        state_d = S_AR;
                    end
                end
                S_AR: begin
                    arvalid = 1'b1;
                    araddr  = addr_q;
                    arlen   = burstLen;
                    arsize  = burstSize;
                    arburst = 2'b01;
                    arid    = ID_VAL;
                    if (arready) state_d = S_R;
                end
                S_R: begin
                    rready = 1'b1;
                    if (rvalid) begin
                        rbuf_d[wordBase +: 32] = rdata;
                        if (rlast) begin
                            cnt_d   = '0;
                            state_d = S_RDONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_RDONE: begin
                    mem_l2cache_dataOK = l2cache_mem_rdy;
                    if (l2cache_mem_rdy) state_d = S_IDLE;
                end
                S_AW: begin
                    awvalid = 1'b1;
                    awaddr  = addr_q;
                    awlen   = burstLen;
                    awsize  = burstSize;
                    awburst = 2'b01;
                    awid    = ID_VAL;
                    if (awready) state_d = S_W;
                end
                S_W: begin
                    wvalid = 1'b1;
                    wdata  = suc_q ? line_q[31:0] : line_q[wordBase +: 32];
                    wstrb  = suc_q ? wstrb_q : 4'hF;
                    wlast  = lastBeat;
                    if (wready) begin
                        if (lastBeat) begin
                            cnt_d   = '0;
                            state_d = S_B;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_B: begin
                    bready = 1'b1;
                    if (bvalid) begin
                        mem_l2cache_dataOK = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/l2_mem_axi_bridge.md
Name: l2_mem_axi_bridge

Overview:
- Responder for the L2 cache memory port: accepts L2 line refills, line write-backs and single uncached (SUC) accesses using the addrOK/dataOK handshake.
- Converts each accepted request into an AXI4 burst (INCR) or a single beat on a 32-bit AXI master.
- Sits between the L2 cache and the system AXI interconnect; one transaction outstanding at a time.

Parameters:
offset_width, 3, log2(words per L2 line); line = 32*(1<<offset_width) bits, burst length = 1<<offset_width beats
ID_VAL, 4'd0, constant arid/awid

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, ACTIVE-HIGH (1 = reset), sampled on clk rising edge
addr_l2cache_mem_r  in  32  read address (line-aligned, or byte address if SUC)
addr_l2cache_mem_w  in  32  write address (line-aligned, or byte address if SUC)
dout_l2cache_mem  in  32<<offset_width  write line; SUC uses bits [31:0]
din_mem_l2cache  out  32<<offset_width  read line / SUC read word in [31:0]
l2cache_mem_req_r  in  1  read request, held until addrOK_r
l2cache_mem_req_w  in  1  write request, held until addrOK_w
l2cache_mem_rdy  in  1  L2 can take read data this cycle
l2cache_mem_SUC  in  1  uncached single access
l2cache_mem_wstrb  in  4  SUC write byte strobe
l2cache_mem_size  in  2  SUC size (0 B, 1 H, 2 W)
mem_l2cache_addrOK_r  out  1  read request accepted
mem_l2cache_addrOK_w  out  1  write request accepted, write data captured
mem_l2cache_dataOK  out  1  transaction complete / read data valid
araddr,arlen,arsize,arburst,arid,arvalid / arready  out 32,8,3,2,4,1 / in 1  AXI AR
rdata,rlast,rvalid / rready  in 32,1,1 / out 1  AXI R
awaddr,awlen,awsize,awburst,awid,awvalid / awready  out 32,8,3,2,4,1 / in 1  AXI AW
wdata,wstrb,wlast,wvalid / wready  out 32,4,1,1 / in 1  AXI W
bvalid / bready  in 1 / out 1  AXI B

Behaviour:
- States: IDLE, AR, R, RDONE, AW, W, B.
- Reset: state IDLE, beat counter 0, din_mem_l2cache 0; while rstn=1, all outputs 0. Reset mid-burst aborts immediately (system-reset only; no AXI completion).
- IDLE acceptance:
  - req_w=1 → addrOK_w=1 this cycle (combinational); latch address, line, SUC, wstrb, size → AW.
  - req_w=0 and req_r=1 → addrOK_r=1; latch address, SUC, size → AR.
  - Both requests high → write wins (dirty eviction precedes refill); read is taken on a later IDLE cycle.
  - addrOK_* is never asserted outside IDLE.
- AR: arvalid=1, araddr=latched address.
  - Line: arlen=(1<<offset_width)-1, arsize=2, arburst=INCR.
  - SUC: arlen=0, arsize={1'b0,size}, arburst=INCR.
  - arready → R.
- R: rready=1. Each rvalid beat writes rdata into word[cnt] of the read buffer, then cnt++ (wraps mod beat count). rlast beat → RDONE, cnt cleared.
  - SUC: word 0 = rdata, all other words 0.
- RDONE: din_mem_l2cache = buffer. dataOK=1 for exactly one cycle, the first cycle with rdy=1 → IDLE. Buffer holds stable while waiting for rdy.
- AW: awvalid=1; same len/size/burst rules as AR. awready → W.
- W: wvalid=1, wdata=latched line word[cnt].
  - Line: wstrb=4'hF.
  - SUC: wdata=line[31:0], wstrb=latched wstrb.
  - wlast=1 when cnt==awlen.
  - wready handshake → cnt++; on the last beat → B, cnt cleared.
- B: bready=1; bvalid → dataOK=1 for one cycle (independent of rdy) → IDLE.
- AXI valids stay high until their ready; address/data are stable while valid=1.
- rresp/bresp are ignored.
- Unknown size value 3 is treated as 2.

Test Plan:
- Line read 0x1C000040, arready delayed 2 cycles, 8 R beats 0x11..0x88 with one idle gap → addrOK_r 1 cycle; arlen=7, arsize=2; dataOK with din word0=0x11 … word7=0x88.
- Line write 0x00000100, line words 0xA0..0xA7, wready low every other cycle → awlen=7; wdata order A0..A7; wlast only on A7; dataOK only after bvalid.
- req_r and req_w both high in IDLE → addrOK_w first; full write completes; then addrOK_r and the read proceeds.
- SUC write: addr 0x1FD00001, size 0, wstrb 4'b0010 → awlen=0, awsize=0, single beat with wlast=1, wstrb=0010; SUC read size 2 rdata 0xDEADBEEF → din[31:0]=0xDEADBEEF, upper bits 0.
- Read complete with rdy=0 for 3 cycles → dataOK stays 0 and din stays stable; dataOK=1 in the cycle rdy rises, single pulse.
- rstn=1 during W beat 3 → next cycle all valids/addrOK/dataOK 0, state IDLE; a new read after reset behaves as in test 1.
